// File: rtl/instr_mem_loader_if.sv
// Bundles the CPU fetch port, the byte-stream load port and the loader status
// signals of instr_mem_loader. The memory side uses the slave modport.
interface instr_mem_loader_if #(
    parameter int DEPTH = 128
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          fetch_req;
    logic [31:0]   a;
    logic [31:0]   rd;
    logic          rd_valid;
    logic          fault;
    logic          load_start;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          load_ready;
    logic          load_end;
    logic          stall;
    logic [LW-1:0] load_words;
    logic          load_done;
    logic          load_err;

    modport master (
        output fetch_req, a, load_start, load_valid, load_byte, load_end,
        input  rd, rd_valid, fault, load_ready, stall, load_words, load_done, load_err
    );

    modport slave (
        input  fetch_req, a, load_start, load_valid, load_byte, load_end,
        output rd, rd_valid, fault, load_ready, stall, load_words, load_done, load_err
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with a 1-cycle fetch port and a little-endian byte-stream
// loader; the CPU is stalled while a load is in progress.
module instr_mem_loader #(
    parameter int          DEPTH    = 128,
    parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
    input  logic              clk,
    input  logic              reset,
    instr_mem_loader_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_WORDS = LW'(DEPTH);
    localparam logic [29:0]   DEPTH_W    = 30'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
    state_t state_reg, state_next;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_reg;
    logic          rd_valid_reg;
    logic          fault_reg;
    logic [LW-1:0] load_words_reg, load_words_next;
    logic [1:0]    lane_reg, lane_next;
    logic [31:0]   asm_reg, asm_next, asm_fill;
    logic          err_seen_reg, err_seen_next;
    logic          load_err_reg, load_err_next;

    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [AW-1:0] ridx;
    logic          accept, full, bad_addr;
    logic          stall, load_ready, load_done;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.load_start) state_next = LOAD;
            LOAD:    if (bus.load_end)   state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        load_ready = 1'b0;
        stall      = 1'b0;
        load_done  = 1'b0;
        case (state_reg)
            LOAD: begin
                load_ready = 1'b1;
                stall      = 1'b1;
            end
            FLUSH:   stall = 1'b1;
            DONE: begin
                stall     = 1'b1;
                load_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = bus.load_valid && load_ready;
    assign full   = (load_words_reg == FULL_WORDS);

    // Drop the incoming byte into its lane; once full, bytes are discarded.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign asm_fill[gi*8 +: 8] = (accept && !full && lane_reg == 2'(gi))
                                     ? bus.load_byte : asm_reg[gi*8 +: 8];
    end

    always_comb begin
        load_words_next = load_words_reg;
        lane_next       = lane_reg;
        asm_next        = asm_reg;
        err_seen_next   = err_seen_reg;
        load_err_next   = 1'b0;
        we              = 1'b0;
        case (state_reg)
            IDLE: if (bus.load_start) begin
                load_words_next = '0;
                lane_next       = 2'd0;
                asm_next        = '0;
                err_seen_next   = 1'b0;
            end
            LOAD: if (accept) begin
                if (full) begin
                    load_err_next = !err_seen_reg;
                    err_seen_next = 1'b1;
                end else if (lane_reg == 2'd3) begin
                    we              = 1'b1;
                    load_words_next = load_words_reg + LW'(1);
                    lane_next       = 2'd0;
                    asm_next        = '0;
                end else begin
                    lane_next = lane_reg + 2'd1;
                    asm_next  = asm_fill;
                end
            end
            FLUSH: begin
                // Unfilled lanes are still zero from the last clear.
                if (lane_reg != 2'd0 && !full) begin
                    we              = 1'b1;
                    load_words_next = load_words_reg + LW'(1);
                end
                lane_next = 2'd0;
                asm_next  = '0;
            end
            default: ;
        endcase
    end

    assign wdata    = asm_fill;
    assign waddr    = load_words_reg[AW-1:0];
    assign ridx     = bus.a[AW+1:2];
    assign bad_addr = (bus.a[1:0] != 2'b00) || (bus.a[31:2] >= DEPTH_W);

    // Memory contents survive reset; only the write port touches them.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_reg         <= NOP_WORD;
            rd_valid_reg   <= 1'b0;
            fault_reg      <= 1'b0;
            load_words_reg <= '0;
            lane_reg       <= 2'd0;
            asm_reg        <= '0;
            err_seen_reg   <= 1'b0;
            load_err_reg   <= 1'b0;
        end else begin
            load_words_reg <= load_words_next;
            lane_reg       <= lane_next;
            asm_reg        <= asm_next;
            err_seen_reg   <= err_seen_next;
            load_err_reg   <= load_err_next;
            if (bus.fetch_req && state_reg == IDLE) begin
                rd_reg       <= bad_addr ? NOP_WORD : mem[ridx];
                rd_valid_reg <= 1'b1;
                fault_reg    <= bad_addr;
            end else begin
                rd_valid_reg <= 1'b0;
                fault_reg    <= 1'b0;
                if (bus.fetch_req) rd_reg <= NOP_WORD;
            end
        end
    end

    assign bus.rd         = rd_reg;
    assign bus.rd_valid   = rd_valid_reg;
    assign bus.fault      = fault_reg;
    assign bus.load_ready = load_ready;
    assign bus.stall      = stall;
    assign bus.load_words = load_words_reg;
    assign bus.load_done  = load_done;
    assign bus.load_err   = load_err_reg;
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of 32-bit instruction words stored.
REQ-002 SHALL have parameter NOP_WORD, default 32'hE1A00000, word returned on faulted or stalled fetches.
REQ-003 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: fetch_req  in  1  fetch request for address a.
REQ-006 SHALL have ports: a  in  32  byte address, word aligned.
REQ-007 SHALL have ports: rd  out  32  fetched instruction word.
REQ-008 SHALL have ports: rd_valid  out  1  rd holds the response to the fetch one cycle earlier.
REQ-009 SHALL have ports: fault  out  1  qualifies rd_valid; the fetch was misaligned or out of range.
REQ-010 SHALL have ports: load_start  in  1  pulse; enter load mode at word 0.
REQ-011 SHALL have ports: load_valid  in  1, load_byte  in  8, load_ready  out  1  byte-stream handshake.
REQ-012 SHALL have ports: load_end  in  1  pulse; terminate load.
REQ-013 SHALL have ports: stall  out  1  CPU must hold PC while high.
REQ-014 SHALL have ports: load_words  out  $clog2(DEPTH)+1  words written in the current/last load.
REQ-015 SHALL have ports: load_done  out  1, load_err  out  1  one-cycle status pulses.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, FLUSH, DONE.
REQ-017 SHALL, in IDLE with fetch_req=1, register mem[a[31:2]] to rd and assert rd_valid the next cycle: latency exactly 1.
REQ-018 SHALL, when a[1:0]!=0 or a[31:2]>=DEPTH, return rd=NOP_WORD with rd_valid=1 and fault=1 the next cycle.
REQ-019 SHALL hold rd and drop rd_valid to 0 in any cycle following fetch_req=0.
REQ-020 SHALL go IDLE->LOAD on load_start, clearing load_words, byte lane counter and word assembler.
REQ-021 SHALL assert load_ready=1 only in LOAD; a byte is accepted when load_valid and load_ready are both 1.
REQ-022 SHALL assemble bytes little-endian: the first accepted byte goes to [7:0], the fourth to [31:24].
REQ-023 SHALL write the word to mem[load_words] in the cycle the fourth byte is accepted, then increment load_words.
REQ-024 SHALL go LOAD->FLUSH on load_end; FLUSH writes a partial word (missing bytes zero) if the lane counter !=0, then goes to DONE.
REQ-025 SHALL, from DONE, pulse load_done for one cycle and return to IDLE.
REQ-026 SHALL, while load_words==DEPTH, drop further accepted bytes, pulse load_err once, and keep accepting bytes until load_end.
REQ-027 SHALL give load_end priority over a byte accepted in the same cycle; that byte is assembled before flush.
REQ-028 SHALL ignore load_start outside IDLE.
REQ-029 SHALL assert stall=1 in LOAD, FLUSH and DONE; fetches in these states return rd=NOP_WORD, rd_valid=0, fault=0.
REQ-030 SHALL, on a fetch to an address written in the same cycle, return the old contents (read-before-write).

Reset
REQ-031 SHALL, on reset=0, asynchronously force FSM=IDLE, rd=NOP_WORD, rd_valid=0, fault=0, stall=0, load_ready=0, load_words=0, load_done=0, load_err=0.
REQ-032 SHALL not clear memory contents on reset; words written before a mid-load reset are retained and the partial word is discarded.
REQ-033 SHALL release reset without glitching outputs; the first fetch is honoured on the first edge after deassertion.

Verification
REQ-034 SHALL cover: load bytes 78 00 A0 E3 then load_end -> mem[0]=E3A00078, load_words=1, load_done pulse, stall 1->0.
REQ-035 SHALL cover: fetch a=0x4 after loading two words -> rd=second word, rd_valid=1 exactly one cycle later, fault=0.
REQ-036 SHALL cover: fetch a=0x6, then a=DEPTH*4 -> rd=E1A00000, fault=1 on both responses.
REQ-037 SHALL cover: load 4*DEPTH+3 bytes -> load_words=DEPTH, single load_err pulse, no wrap to mem[0].
REQ-038 SHALL cover: load 6 bytes then load_end -> word 1 = {16'h0000, byte5, byte4}, load_words=2.
REQ-039 SHALL cover: reset asserted after 2 words plus 1 byte -> FSM=IDLE immediately, mem[0..1] intact, stall=0.
